// File: rtl/mpu6050_sequencer.sv
// MPU6050 accelerometer sequencer: wakes the sensor once, then reads ACCEL_XOUT_H..ACCEL_ZOUT_L
// as six single-byte I2C reads every SAMPLE_PERIOD cycles, publishing all three axes together.
module mpu6050_sequencer #(
  parameter logic [6:0] SLAVE_ADDR    = 7'h68,
  parameter int         SAMPLE_PERIOD = 500_000,
  parameter int         TIMEOUT       = 100_000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               i2c_enable,
  output logic               i2c_rw,
  output logic [6:0]         i2c_slave_addr,
  output logic [7:0]         i2c_reg_addr,
  output logic [7:0]         i2c_data_wr,
  input  logic [7:0]         i2c_data_rd,
  input  logic               i2c_busy,
  input  logic               i2c_ack_error,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic signed [15:0] accel_z,
  output logic               sample_valid,
  output logic               init_done,
  output logic               err
);

  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    INIT_REQ,
    INIT_WAIT,
    PERIOD_WAIT,
    RD_REQ,
    RD_WAIT,
    PUBLISH
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_period;
  logic [TW-1:0]        r_tmo;
  logic                 r_nack;
  logic [2:0]           r_idx;
  logic [47:0]          r_shift;
  logic                 r_enable;
  logic                 r_rw;
  logic [7:0]           r_reg_addr;
  logic [7:0]           r_data_wr;
  logic signed [15:0]   r_ax;
  logic signed [15:0]   r_ay;
  logic signed [15:0]   r_az;
  logic                 r_valid;
  logic                 r_init_done;
  logic                 r_err;

  logic w_wrap;
  logic w_tmo;
  logic w_is_rd;

  assign w_wrap  = (r_period == PW'(SAMPLE_PERIOD - 1));
  assign w_tmo   = (r_tmo == TW'(TIMEOUT - 1));
  assign w_is_rd = (r_state == RD_REQ) || (r_state == RD_WAIT);

  assign i2c_enable     = r_enable;
  assign i2c_rw         = r_rw;
  assign i2c_slave_addr = SLAVE_ADDR;
  assign i2c_reg_addr   = r_reg_addr;
  assign i2c_data_wr    = r_data_wr;
  assign accel_x        = r_ax;
  assign accel_y        = r_ay;
  assign accel_z        = r_az;
  assign sample_valid   = r_valid;
  assign init_done      = r_init_done;
  assign err            = r_err;

  // Free-running cadence counter; wraps that land mid-burst are simply not observed by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
    end else if (w_wrap) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= INIT_REQ;
      r_tmo       <= '0;
      r_nack      <= 1'b0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_enable    <= 1'b0;
      r_rw        <= 1'b0;
      r_reg_addr  <= '0;
      r_data_wr   <= '0;
      r_ax        <= '0;
      r_ay        <= '0;
      r_az        <= '0;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        INIT_REQ, RD_REQ: begin
          if (w_tmo) begin
            r_enable <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= PERIOD_WAIT;
          end else begin
            r_tmo <= r_tmo + 1'b1;
            // The command is loaded only while the bus is idle so enable never rises onto a busy master.
            if (r_enable && i2c_busy) begin
              r_enable <= 1'b0;
              r_nack   <= i2c_ack_error;
              r_state  <= w_is_rd ? RD_WAIT : INIT_WAIT;
            end else if (!r_enable && !i2c_busy) begin
              r_enable   <= 1'b1;
              r_rw       <= w_is_rd;
              r_reg_addr <= w_is_rd ? (8'h3B + {5'd0, r_idx}) : 8'h6B;
              r_data_wr  <= 8'h00;
            end
          end
        end

        INIT_WAIT, RD_WAIT: begin
          if (!i2c_busy) begin
            r_state <= PERIOD_WAIT;
            if (r_nack) begin
              r_err <= 1'b1;
            end else if (r_state == INIT_WAIT) begin
              r_init_done <= 1'b1;
            end else begin
              r_shift <= {r_shift[39:0], i2c_data_rd};
              if (r_idx == 3'd5) begin
                r_state <= PUBLISH;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_tmo   <= '0;
                r_nack  <= 1'b0;
                r_state <= RD_REQ;
              end
            end
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= PERIOD_WAIT;
          end else begin
            r_tmo  <= r_tmo + 1'b1;
            r_nack <= r_nack | i2c_ack_error;
          end
        end

        PERIOD_WAIT: begin
          if (w_wrap) begin
            r_tmo   <= '0;
            r_nack  <= 1'b0;
            r_idx   <= '0;
            r_state <= r_init_done ? RD_REQ : INIT_REQ;
          end
        end

        PUBLISH: begin
          // Oldest byte (ACCEL_XOUT_H) has been shifted to the top of the 48-bit window.
          r_ax    <= $signed(r_shift[47:32]);
          r_ay    <= $signed(r_shift[31:16]);
          r_az    <= $signed(r_shift[15:0]);
          r_valid <= 1'b1;
          r_state <= PERIOD_WAIT;
        end

        default: begin
          r_enable <= 1'b0;
          r_state  <= INIT_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu6050_sequencer.sv
// Self-checking bench for mpu6050_sequencer: a reactive I2C master model with random data and
// latency, a burst-level reference of the expected axes, and scenario checks for NACK, timeout and reset.
module tb_mpu6050_sequencer;

  localparam int SP = 2000;
  localparam int TO = 500;

  typedef struct {
    logic       rw;
    logic [7:0] regAddr;
    logic [7:0] wdat;
    int         cyc;
  } txn_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i2c_enable;
  logic               i2c_rw;
  logic [6:0]         i2c_slave_addr;
  logic [7:0]         i2c_reg_addr;
  logic [7:0]         i2c_data_wr;
  logic [7:0]         i2c_data_rd = 8'h00;
  logic               i2c_busy = 1'b0;
  logic               i2c_ack_error = 1'b0;
  logic signed [15:0] accel_x;
  logic signed [15:0] accel_y;
  logic signed [15:0] accel_z;
  logic               sample_valid;
  logic               init_done;
  logic               err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Bus-model configuration (written by the test flow only)
  int   dataMode = 0;
  int   randLat = 1;
  logic [7:0] nackReg = 8'h00;
  int   nackSeq = 0;
  int   hangSeq = 0;
  logic hangRelease = 1'b1;

  // Bus-model and reference state (written by the model only)
  txn_t       txnLog[$];
  logic [7:0] burstBytes[$];
  int         pulseCycs[$];
  int         validCount = 0;
  int         enViolations = 0;
  int         nackDone = 0;
  int         hangDone = 0;
  logic       bmActive = 1'b0;
  logic       bmHang = 1'b0;
  int         bmLeft = 0;
  logic [7:0] rdData;
  logic       expOk = 1'b0;
  logic [15:0] expX = '0;
  logic [15:0] expY = '0;
  logic [15:0] expZ = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mpu6050_sequencer #(
    .SLAVE_ADDR    (7'h68),
    .SAMPLE_PERIOD (SP),
    .TIMEOUT       (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i2c_enable     (i2c_enable),
    .i2c_rw         (i2c_rw),
    .i2c_slave_addr (i2c_slave_addr),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_data_wr    (i2c_data_wr),
    .i2c_data_rd    (i2c_data_rd),
    .i2c_busy       (i2c_busy),
    .i2c_ack_error  (i2c_ack_error),
    .accel_x        (accel_x),
    .accel_y        (accel_y),
    .accel_z        (accel_z),
    .sample_valid   (sample_valid),
    .init_done      (init_done),
    .err            (err)
  );

  // I2C master model plus burst reference: the expected axes are whatever the last six reads
  // of one burst (starting at 0x3B) returned, paired big-endian.
  always @(negedge clk) begin
    if (!rst_n) begin
      i2c_busy      = 1'b0;
      i2c_ack_error = 1'b0;
      bmActive      = 1'b0;
      bmHang        = 1'b0;
    end else begin
      if (sample_valid) begin
        validCount++;
        pulseCycs.push_back(cyc);
        expOk = (burstBytes.size() == 6);
        if (expOk) begin
          expX = {burstBytes[0], burstBytes[1]};
          expY = {burstBytes[2], burstBytes[3]};
          expZ = {burstBytes[4], burstBytes[5]};
        end
      end
      if (bmActive) begin
        if (i2c_enable) enViolations++;
        if (bmHang && !hangRelease) begin
          bmLeft = bmLeft;
        end else if (bmLeft == 0) begin
          i2c_busy      = 1'b0;
          i2c_ack_error = 1'b0;
          bmActive      = 1'b0;
          bmHang        = 1'b0;
        end else begin
          bmLeft--;
        end
      end else if (i2c_enable) begin
        txnLog.push_back('{i2c_rw, i2c_reg_addr, i2c_data_wr, cyc});
        bmActive = 1'b1;
        i2c_busy = 1'b1;
        bmLeft   = (randLat != 0) ? int'($urandom_range(1, 5)) : 2;
        if (nackSeq != nackDone && i2c_reg_addr == nackReg) begin
          i2c_ack_error = 1'b1;
          nackDone      = nackSeq;
        end
        if (hangSeq != hangDone) begin
          bmHang   = 1'b1;
          hangDone = hangSeq;
        end
        if (i2c_rw) begin
          rdData = (dataMode != 0) ? 8'($urandom_range(0, 255)) : i2c_reg_addr;
          i2c_data_rd = rdData;
          if (i2c_reg_addr == 8'h3B) burstBytes.delete();
          burstBytes.push_back(rdData);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reset with the given bus-model configuration, checking the reset values while held.
  task automatic applyStimulus(input int dMode, input int rLat);
    dataMode = dMode;
    randLat  = rLat;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstEnable", 32'(i2c_enable), 32'd0);
    checkOutput("rstRegAddr", {24'd0, i2c_reg_addr}, 32'd0);
    checkOutput("rstAccel", {accel_x, accel_y} | {16'd0, accel_z}, 32'd0);
    checkOutput("rstFlags", {28'd0, i2c_rw, sample_valid, init_done, err}, 32'd0);
    checkOutput("slaveAddr", {25'd0, i2c_slave_addr}, 32'h68);
    rst_n = 1'b1;
  endtask

  task automatic waitLog(input int n, input int budget, input string tag);
    int k = 0;
    while (txnLog.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(txnLog.size() >= n), 32'd1);
  endtask

  task automatic waitValid(input int n, input int budget, input string tag);
    int k = 0;
    while (validCount < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(validCount >= n), 32'd1);
  endtask

  task automatic checkAxesModel(input string tag);
    checkOutput({tag, "Burst"}, 32'(expOk), 32'd1);
    checkOutput({tag, "X"}, {16'd0, accel_x}, {16'd0, expX});
    checkOutput({tag, "Y"}, {16'd0, accel_y}, {16'd0, expY});
    checkOutput({tag, "Z"}, {16'd0, accel_z}, {16'd0, expZ});
  endtask

  initial begin
    #(10 * 100_000);
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int logBase;
    int v;
    int c0;
    int k;
    logic found;
    logic signed [15:0] prevX, prevY, prevZ;

    // Wake-up write then the first burst with address-valued data
    applyStimulus(0, 1);
    logBase = txnLog.size();
    waitValid(1, 5000, "t1Pulse");
    checkOutput("t1InitWr", {15'd0, txnLog[logBase].rw, txnLog[logBase].regAddr, txnLog[logBase].wdat},
                {15'd0, 1'b0, 8'h6B, 8'h00});
    checkOutput("t1InitDone", 32'(init_done), 32'd1);
    checkOutput("t1Err", 32'(err), 32'd0);
    for (int i = 0; i < 6; i++)
      checkOutput("t1RdAddr", {23'd0, txnLog[logBase + 1 + i].rw, txnLog[logBase + 1 + i].regAddr},
                  {23'd0, 1'b1, 8'(8'h3B + i)});
    checkOutput("t1AccelX", {16'd0, accel_x}, 32'h3B3C);
    checkOutput("t1AccelY", {16'd0, accel_y}, 32'h3D3E);
    checkOutput("t1AccelZ", {16'd0, accel_z}, 32'h3F40);

    // Steady run with random data: cadence and read order
    dataMode = 1;
    randLat  = 0;
    logBase  = txnLog.size();
    v        = validCount;
    waitValid(v + 3, 7000, "t2Pulses");
    checkOutput("t2Interval1", 32'(pulseCycs[pulseCycs.size() - 1] - pulseCycs[pulseCycs.size() - 2]), 32'(SP));
    checkOutput("t2Interval2", 32'(pulseCycs[pulseCycs.size() - 2] - pulseCycs[pulseCycs.size() - 3]), 32'(SP));
    checkOutput("t2LogLen", 32'(txnLog.size() - logBase), 32'd18);
    for (int i = 0; i < 18; i++)
      checkOutput("t2RdAddr", {23'd0, txnLog[logBase + i].rw, txnLog[logBase + i].regAddr},
                  {23'd0, 1'b1, 8'(8'h3B + (i % 6))});
    checkAxesModel("t2Axes");

    // NACK on 0x3E: burst discarded, next period recovers
    randLat = 1;
    prevX = accel_x;
    prevY = accel_y;
    prevZ = accel_z;
    v = validCount;
    logBase = txnLog.size();
    nackReg = 8'h3E;
    nackSeq++;
    waitLog(logBase + 4, 2500, "t3ReachNack");
    repeat (60) @(negedge clk);
    checkOutput("t3Err", 32'(err), 32'd1);
    checkOutput("t3NoPulse", 32'(validCount), 32'(v));
    checkOutput("t3Held", {accel_x, accel_y} ^ {prevX, prevY}, 32'd0);
    checkOutput("t3HeldZ", {16'd0, accel_z}, {16'd0, prevZ});
    checkOutput("t3Aborted", 32'(txnLog.size() - logBase), 32'd4);
    waitValid(v + 1, 2500, "t3Recover");
    checkOutput("t3RecoverLen", 32'(txnLog.size() - logBase), 32'd10);
    checkAxesModel("t3Axes");

    // NACK on the wake-up write, then retry one period later
    nackReg = 8'h6B;
    nackSeq++;
    logBase = txnLog.size();
    applyStimulus(1, 1);
    waitLog(logBase + 1, 50, "t4FirstWr");
    repeat (100) @(negedge clk);
    checkOutput("t4Err", 32'(err), 32'd1);
    checkOutput("t4NotInit", 32'(init_done), 32'd0);
    checkOutput("t4NoRead", 32'(txnLog.size() - logBase), 32'd1);
    waitLog(logBase + 2, 2200, "t4Retry");
    checkOutput("t4RetryWr", {23'd0, txnLog[logBase + 1].rw, txnLog[logBase + 1].regAddr},
                {23'd0, 1'b0, 8'h6B});
    checkOutput("t4RetryGap", 32'(txnLog[logBase + 1].cyc - txnLog[logBase].cyc), 32'(SP));
    repeat (50) @(negedge clk);
    checkOutput("t4InitDone", 32'(init_done), 32'd1);
    checkOutput("t4ErrSticky", 32'(err), 32'd1);

    // Master hangs busy: timeout after TIMEOUT cycles
    hangRelease = 1'b0;
    hangSeq++;
    logBase = txnLog.size();
    applyStimulus(1, 1);
    waitLog(logBase + 1, 50, "t5Start");
    c0 = txnLog[txnLog.size() - 1].cyc;
    while (cyc < c0 + 400) @(negedge clk);
    checkOutput("t5ErrEarly", 32'(err), 32'd0);
    while (cyc < c0 + 520) @(negedge clk);
    checkOutput("t5ErrTimeout", 32'(err), 32'd1);
    hangRelease = 1'b1;
    k = 0;
    while (!init_done && k < 2500) begin
      @(negedge clk);
      k++;
    end
    checkOutput("t5InitRetry", 32'(init_done), 32'd1);
    checkOutput("t5RetryCount", 32'(txnLog.size() - logBase), 32'd2);

    // Reset during the read of 0x3D
    dataMode = 0;
    logBase = txnLog.size();
    found = 1'b0;
    k = 0;
    while (!found && k < 5000) begin
      @(negedge clk);
      k++;
      if (txnLog.size() > logBase && txnLog[txnLog.size() - 1].regAddr == 8'h3D &&
          txnLog[txnLog.size() - 1].rw && i2c_busy) found = 1'b1;
    end
    checkOutput("t6Found3D", 32'(found), 32'd1);
    checkOutput("t6PreInit", 32'(init_done), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6AsyncAccel", {accel_x, accel_y} | {16'd0, accel_z}, 32'd0);
    checkOutput("t6AsyncFlags", {27'd0, i2c_enable, i2c_rw, sample_valid, init_done, err}, 32'd0);
    checkOutput("t6AsyncReg", {16'd0, i2c_reg_addr, i2c_data_wr}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    logBase = txnLog.size();
    waitLog(logBase + 1, 50, "t6Restart");
    checkOutput("t6RestartWr", {15'd0, txnLog[logBase].rw, txnLog[logBase].regAddr, txnLog[logBase].wdat},
                {15'd0, 1'b0, 8'h6B, 8'h00});
    v = validCount;
    waitValid(v + 1, 2500, "t6Pulse");
    checkOutput("t6AccelX", {16'd0, accel_x}, 32'h3B3C);
    checkAxesModel("t6Axes");

    checkOutput("enableWhileBusy", 32'(enViolations), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpu6050_sequencer.md
MPU6050_SEQUENCER -- requirements
Module: mpu6050_sequencer

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h68, the MPU6050 7-bit I2C address.
REQ-002 SHALL have parameter SAMPLE_PERIOD, default 500_000, the clk cycles between sample-burst starts (100 Hz at 50 MHz).
REQ-003 SHALL have parameter TIMEOUT, default 100_000, the maximum clk cycles to wait on one I2C transaction.
REQ-004 clk  input  1  system clock, 50 MHz; one clock; all logic on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 i2c_enable  output  1  transaction request to the I2C master.
REQ-007 i2c_rw  output  1  1 = read, 0 = write.
REQ-008 i2c_slave_addr  output  7  constant SLAVE_ADDR.
REQ-009 i2c_reg_addr  output  8  MPU6050 register address.
REQ-010 i2c_data_wr  output  8  write data.
REQ-011 i2c_data_rd  input  8  read data from the master; holds its value after busy falls.
REQ-012 i2c_busy  input  1  master transaction in progress.
REQ-013 i2c_ack_error  input  1  master NACK flag; valid only while i2c_busy=1.
REQ-014 accel_x, accel_y, accel_z  output  16 each  signed samples, {H,L}.
REQ-015 sample_valid  output  1  one-cycle pulse when all three axes update together.
REQ-016 init_done  output  1  wake-up write succeeded.
REQ-017 err  output  1  sticky; set on NACK or timeout.

Function
REQ-018 SHALL use these states: INIT_REQ, INIT_WAIT, PERIOD_WAIT, RD_REQ, RD_WAIT, PUBLISH.
REQ-019 After reset SHALL enter INIT_REQ and issue a write of 8'h00 to register 8'h6B (PWR_MGMT_1).
REQ-020 Request handshake (x_REQ states): hold i2c_enable=1 with rw/reg_addr/data_wr stable until i2c_busy=1 is sampled, then drop i2c_enable on the next edge and enter x_WAIT.
REQ-021 x_WAIT SHALL OR i2c_ack_error into an internal nack flag on every cycle where i2c_busy=1; the transaction is complete on the first cycle where i2c_busy=0.
REQ-022 Clear the nack flag and the timeout counter on entry to every x_REQ state.
REQ-023 The timeout counter SHALL count every cycle spent in x_REQ and x_WAIT; reaching TIMEOUT-1 SHALL count as a failure.
REQ-024 INIT_WAIT complete without nack: set init_done=1, go to PERIOD_WAIT.
REQ-025 INIT_WAIT failure (nack or timeout): set err=1, go to PERIOD_WAIT with init_done=0; when the period expires, retry INIT_REQ.
REQ-026 PERIOD_WAIT: the period counter free-runs from 0 to SAMPLE_PERIOD-1 and wraps; at wrap, go to INIT_REQ if init_done=0, else to RD_REQ with byte index 0.
REQ-027 The period counter SHALL keep running in all states, so the burst start cadence is exactly SAMPLE_PERIOD cycles. If a wrap occurs while a burst is still in progress, that wrap SHALL be ignored (no queuing).
REQ-028 RD_REQ SHALL issue a single-byte read (rw=1) of reg_addr = 8'h3B + index, for index 0..5 (8'h3B..8'h40).
REQ-029 RD_WAIT complete without nack: store i2c_data_rd into byte[index]. If index<5, increment it and return to RD_REQ; otherwise go to PUBLISH.
REQ-030 RD_WAIT failure: set err=1, discard the partial burst (no output update, no pulse), go to PERIOD_WAIT.
REQ-031 PUBLISH (one cycle): update all three axes in the same cycle:
  - accel_x = {byte0, byte1}
  - accel_y = {byte2, byte3}
  - accel_z = {byte4, byte5}
  Pulse sample_valid=1 for that cycle, then go to PERIOD_WAIT.
REQ-032 i2c_enable SHALL never be asserted while i2c_busy=1 outside the x_REQ handshake.
REQ-033 err SHALL be cleared only by reset.

Reset
REQ-034 On rst_n=0, all outputs and registers SHALL clear asynchronously: i2c_enable=0, i2c_rw=0, i2c_reg_addr=0, i2c_data_wr=0, accel_x/y/z=0, sample_valid=0, init_done=0, err=0, counters=0; state = INIT_REQ.
REQ-035 Reset asserted mid-transaction SHALL abort immediately. After release, the sequence restarts from INIT_REQ, and the previously sampled data is not retained.

Verification
REQ-036 Set SAMPLE_PERIOD=2000 and attach a bus model that ACKs everything and returns data 8'h3B..8'h40 -> write to 0x6B of 0x00 first; init_done=1; sample_valid pulses once with accel_x=16'h3B3C, accel_y=16'h3D3E, accel_z=16'h3F40.
REQ-037 Steady run -> successive sample_valid pulses exactly 2000 cycles apart; each burst reads 0x3B..0x40 in ascending order.
REQ-038 NACK on the init write -> err=1, init_done=0, no read issued; the 0x6B write is retried after 2000 cycles, and on success init_done=1.
REQ-039 NACK on the read of 0x3E -> err=1, outputs keep their previous values, no sample_valid pulse; the next period produces a full burst.
REQ-040 Master holds busy=1 with TIMEOUT=500 -> after 500 cycles err=1 and the state returns to PERIOD_WAIT.
REQ-041 rst_n pulsed low during the read of 0x3D -> all outputs are 0 immediately; after release, the init write reissues.
